player_input_decoder: RTL and testbench

Converts the four raw USB keyboard keycode slots from the SoC's keycode PIOs into per-player, frame-aligned command words for the player-motion stage. Sits directly upstream of PlayerControl:
- It decodes movement and attack keys for both fighters.
- It captures attack presses that occur anywhere within a frame.
- It enforces a per-player attack cooldown counted in frames.
- It presents stable commands that change only once per frame, at the rising edge of the vertical-sync signal.

---
 rtl/player_input_decoder.sv | 154 +++++++++++++++
 tb/tb_player_input_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_decoder.sv
// Keyboard keycode slots -> per-player frame-aligned command words with
// sub-frame attack capture and a per-player attack cooldown counted in frames.
package player_input_pkg;
  typedef struct packed {
    logic kick;
    logic punch;
    logic crouch;
    logic jump;
    logic right;
    logic left;
  } cmd_t;
endpackage

module player_lane
  import player_input_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_edge,
  input  logic [3:0] move,      // {crouch, jump, right, left} held this cycle
  input  logic [1:0] press,     // {kick, punch} 0->1 transitions this cycle
  output cmd_t       cmd,
  output logic [3:0] cooldown
);
  localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_FRAMES);

  logic [1:0] pend, pend_eff;
  cmd_t       next_cmd;
  logic [3:0] next_cd;

  // A press landing on the edge cycle itself still counts for that edge.
  assign pend_eff = pend | press;

  always_comb begin
    next_cmd        = '0;
    next_cd         = cooldown;
    next_cmd.left   = move[0] & ~move[1];
    next_cmd.right  = move[1] & ~move[0];
    next_cmd.jump   = move[2];
    next_cmd.crouch = move[3] & ~move[2];
    if (cooldown == 4'd0) begin
      if (pend_eff[0]) begin
        next_cmd.punch = 1'b1;
        next_cd        = CD_LOAD;
      end else if (pend_eff[1]) begin
        next_cmd.kick = 1'b1;
        next_cd       = CD_LOAD;
      end
    end else begin
      next_cd = cooldown - 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend     <= '0;
      cmd      <= '0;
      cooldown <= '0;
    end else if (frame_edge) begin
      pend     <= '0;
      cmd      <= next_cmd;
      cooldown <= next_cd;
    end else begin
      pend <= pend_eff;
    end
  end
endmodule

module player_input_decoder
  import player_input_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  output logic [5:0] p1_cmd,
  output logic [5:0] p2_cmd,
  output logic       cmd_valid,
  output logic [3:0] p1_cooldown,
  output logic [3:0] p2_cooldown
);
  localparam int NUM_PLAYERS = 2;

  logic [3:0][7:0]                   slots;
  logic [NUM_PLAYERS-1:0][5:0]       held_d, held_q;
  logic [NUM_PLAYERS-1:0][1:0]       atk_prev, press;
  cmd_t [NUM_PLAYERS-1:0]            cmd;
  logic [NUM_PLAYERS-1:0][3:0]       cd;
  logic                              vs_q, frame_edge;

  assign slots      = {keycode_3, keycode_2, keycode_1, keycode_0};
  assign frame_edge = frame_vs & ~vs_q;

  always_comb begin
    held_d = '0;
    for (int s = 0; s < 4; s++) begin
      case (slots[s])
        8'h04: held_d[0][0] = 1'b1;
        8'h07: held_d[0][1] = 1'b1;
        8'h1A: held_d[0][2] = 1'b1;
        8'h16: held_d[0][3] = 1'b1;
        8'h09: held_d[0][4] = 1'b1;
        8'h0A: held_d[0][5] = 1'b1;
        8'h50: held_d[1][0] = 1'b1;
        8'h4F: held_d[1][1] = 1'b1;
        8'h52: held_d[1][2] = 1'b1;
        8'h51: held_d[1][3] = 1'b1;
        8'h0E: held_d[1][4] = 1'b1;
        8'h0F: held_d[1][5] = 1'b1;
        default: ;
      endcase
    end
  end

  // vs_q resets high so a frame_vs already high at reset release is not an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q      <= 1'b1;
      held_q    <= '0;
      atk_prev  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      vs_q      <= frame_vs;
      held_q    <= held_d;
      cmd_valid <= frame_edge;
      for (int i = 0; i < NUM_PLAYERS; i++) atk_prev[i] <= held_q[i][5:4];
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    assign press[i] = held_q[i][5:4] & ~atk_prev[i];
    player_lane #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_lane (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_edge(frame_edge),
      .move      (held_q[i][3:0]),
      .press     (press[i]),
      .cmd       (cmd[i]),
      .cooldown  (cd[i])
    );
  end

  assign p1_cmd      = cmd[0];
  assign p2_cmd      = cmd[1];
  assign p1_cooldown = cd[0];
  assign p2_cooldown = cd[1];
endmodule

// File: tb/tb_player_input_decoder.sv
// Bench for player_input_decoder: movement vector table, hand-written attack
// and reset sequences, then random keys/vsync against a reference model.
module tb_player_input_decoder;
  localparam int CD = 12;
  localparam logic [7:0] KEYMAP [12] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h09, 8'h0A,
                                         8'h50, 8'h4F, 8'h52, 8'h51, 8'h0E, 8'h0F};

  logic       Clk = 1'b0;
  logic       Reset, frame_vs;
  logic [7:0] k0, k1, k2, k3;
  logic [5:0] p1_cmd, p2_cmd;
  logic       cmd_valid;
  logic [3:0] p1_cooldown, p2_cooldown;

  int tests = 0;
  int fails = 0;

  always #10 Clk = ~Clk;

  player_input_decoder #(.COOLDOWN_FRAMES(CD)) dut (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs),
    .keycode_0(k0), .keycode_1(k1), .keycode_2(k2), .keycode_3(k3),
    .p1_cmd(p1_cmd), .p2_cmd(p2_cmd), .cmd_valid(cmd_valid),
    .p1_cooldown(p1_cooldown), .p2_cooldown(p2_cooldown)
  );

  // Reference model: held sets, pending presses and cooldowns as per-player values.
  typedef struct packed {
    logic            vsq;
    logic [11:0]     held;
    logic [11:0]     prev;
    logic            valid;
    logic [1:0]      pend_p;
    logic [1:0]      pend_k;
    logic [1:0][3:0] cd;
    logic [1:0][5:0] cmd;
  } m_t;
  m_t m;

  function automatic logic [11:0] m_decode(input logic [7:0] a, b, c, d);
    logic [11:0] h;
    logic [7:0]  sl [4];
    sl[0] = a; sl[1] = b; sl[2] = c; sl[3] = d;
    h = '0;
    for (int i = 0; i < 12; i++)
      for (int s = 0; s < 4; s++)
        if (sl[s] == KEYMAP[i]) h[i] = 1'b1;
    return h;
  endfunction

  function automatic m_t m_next(input m_t s, input logic rst, input logic vs,
                                input logic [7:0] a, b, c, d);
    m_t         n;
    logic       edge_now, pp, pk;
    logic [5:0] cm;
    int         bb;
    n = s;
    if (rst) begin
      n = '0;
      n.vsq = 1'b1;
      return n;
    end
    edge_now = vs && !s.vsq;
    n.vsq    = vs;
    n.held   = m_decode(a, b, c, d);
    n.prev   = s.held;
    n.valid  = edge_now;
    for (int p = 0; p < 2; p++) begin
      bb = p * 6;
      pp = s.pend_p[p] || (s.held[bb+4] && !s.prev[bb+4]);
      pk = s.pend_k[p] || (s.held[bb+5] && !s.prev[bb+5]);
      if (edge_now) begin
        cm    = '0;
        cm[0] = s.held[bb] && !s.held[bb+1];
        cm[1] = s.held[bb+1] && !s.held[bb];
        cm[2] = s.held[bb+2];
        cm[3] = s.held[bb+3] && !s.held[bb+2];
        if (s.cd[p] == 0) begin
          if (pp) begin cm[4] = 1'b1; n.cd[p] = 4'(CD); end
          else if (pk) begin cm[5] = 1'b1; n.cd[p] = 4'(CD); end
        end else begin
          n.cd[p] = s.cd[p] - 4'd1;
        end
        n.cmd[p]    = cm;
        n.pend_p[p] = 1'b0;
        n.pend_k[p] = 1'b0;
      end else begin
        n.pend_p[p] = pp;
        n.pend_k[p] = pk;
      end
    end
    return n;
  endfunction

  always @(posedge Clk) m <= m_next(m, Reset, frame_vs, k0, k1, k2, k3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_keys(input logic [7:0] a, b, c, d);
    k0 = a; k1 = b; k2 = c; k3 = d;
  endtask

  // Leaves us one cycle after the cmd_valid pulse; outputs are then held.
  task automatic frame_edge(input int low);
    frame_vs = 1'b0;
    step(low);
    frame_vs = 1'b1;
    step(1);
    check("cmd_valid_pulse", cmd_valid, 1);
    step(1);
    check("cmd_valid_drop", cmd_valid, 0);
  endtask

  task automatic press_f();
    k1 = 8'h09;
    step(3);
    k1 = 8'h00;
    step(3);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [5:0] e1, e2;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic seen;
    int   kc_t, vs_t;
    Reset = 1'b1; frame_vs = 1'b1;
    set_keys(0, 0, 0, 0);
    vecs[0] = '{8'h07, 8'h00, 8'h52, 8'h00, 6'h02, 6'h04};
    vecs[1] = '{8'h07, 8'h04, 8'h52, 8'h00, 6'h00, 6'h04};
    vecs[2] = '{8'h1A, 8'h16, 8'h00, 8'h00, 6'h04, 6'h00};
    vecs[3] = '{8'h50, 8'h51, 8'h52, 8'h00, 6'h00, 6'h05};
    vecs[4] = '{8'h04, 8'h04, 8'h4F, 8'h33, 6'h01, 6'h02};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 6'h00, 6'h00};
    vecs[6] = '{8'h16, 8'h07, 8'h51, 8'h50, 6'h0A, 6'h09};
    vecs[7] = '{8'h00, 8'h51, 8'h50, 8'h4F, 6'h00, 6'h08};

    step(3);
    check("reset_state", {p1_cmd, p2_cmd, cmd_valid, p1_cooldown, p2_cooldown}, 0);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen = seen | cmd_valid;
    end
    check("no_valid_vs_high_at_release", seen, 0);
    frame_edge(2);
    check("first_frame_outputs", {p1_cmd, p2_cmd, p1_cooldown, p2_cooldown}, 0);

    foreach (vecs[i]) begin
      set_keys(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      step(3);
      frame_edge(2);
      check($sformatf("move_p1[%0d]", i), p1_cmd, vecs[i].e1);
      check($sformatf("move_p2[%0d]", i), p2_cmd, vecs[i].e2);
    end

    // Sub-frame press: three-cycle tap between edges.
    set_keys(0, 0, 0, 0);
    step(3);
    press_f();
    frame_edge(2);
    check("subframe_punch_cmd", p1_cmd, 6'h10);
    check("subframe_punch_cd", p1_cooldown, 12);
    step(5);
    check("midframe_hold", {p1_cmd, p1_cooldown}, {6'h10, 4'd12});
    frame_edge(2);
    check("punch_one_frame_cmd", p1_cmd, 6'h00);
    check("punch_one_frame_cd", p1_cooldown, 11);

    // Cooldown lockout: press at edge 0, 4 (discarded) and 13 (free again).
    pulse_reset();
    step(1);
    press_f();
    frame_edge(2);
    check("lockout_first", {p1_cmd, p1_cooldown}, {6'h10, 4'd12});
    for (int e = 1; e <= 13; e++) begin
      if (e == 4 || e == 13) press_f();
      else step(2);
      frame_edge(2);
      check($sformatf("lockout_cmd[%0d]", e), p1_cmd, (e == 13) ? 6'h10 : 6'h00);
      check($sformatf("lockout_cd[%0d]", e), p1_cooldown, (e == 13) ? 12 : 12 - e);
    end

    // Simultaneous punch+kick for player 2; p1 cooldown runs independently.
    set_keys(8'h0E, 8'h00, 8'h0F, 8'h00);
    step(3);
    frame_edge(2);
    check("simul_p2_cmd", p2_cmd, 6'h10);
    check("simul_p2_cd", p2_cooldown, 12);
    check("simul_p1_indep_cd", p1_cooldown, 11);
    for (int f = 0; f < 20; f++) begin
      frame_edge(2);
      check($sformatf("hold_no_retrigger[%0d]", f), p2_cmd, 6'h00);
    end
    check("hold_cd_expired", p2_cooldown, 0);
    set_keys(0, 0, 0, 0);
    step(3);

    // Reset mid-cooldown, then a fresh press after a one-cycle vsync glitch.
    pulse_reset();
    step(1);
    press_f();
    frame_edge(2);
    repeat (5) frame_edge(2);
    check("pre_reset_cd", p1_cooldown, 7);
    Reset = 1'b1;
    step(1);
    check("mid_reset_outputs", {p1_cmd, p2_cmd, cmd_valid, p1_cooldown, p2_cooldown}, 0);
    Reset = 1'b0;
    press_f();
    frame_edge(1);
    check("post_reset_press", {p1_cmd, p1_cooldown}, {6'h10, 4'd12});

    // Random keys and vsync against the model.
    kc_t = 1; vs_t = 1;
    for (int c = 0; c < 4000; c++) begin
      step(1);
      check("random_cycle", {p1_cmd, p2_cmd, cmd_valid, p1_cooldown, p2_cooldown},
            {m.cmd[0], m.cmd[1], m.valid, m.cd[0], m.cd[1]});
      kc_t--;
      if (kc_t <= 0) begin
        int r;
        kc_t = $urandom_range(1, 6);
        r = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) k0 = (r < 12) ? KEYMAP[r] : 8'h00;
        r = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) k1 = (r < 12) ? KEYMAP[r] : 8'h2C;
        r = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) k2 = (r < 12) ? KEYMAP[r] : 8'h00;
        r = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) k3 = (r < 12) ? KEYMAP[r] : 8'h00;
      end
      vs_t--;
      if (vs_t <= 0) begin
        frame_vs = ~frame_vs;
        vs_t = frame_vs ? $urandom_range(2, 12) : $urandom_range(1, 5);
      end
      Reset = ($urandom_range(0, 599) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
